// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI3 RAM responder.
package axi_ram_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_DATA_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrData,
        StWrResp
    } state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address unit (FIXED/INCR, plus WRAP when AXI_RAM_WRAP_EN is defined).
module axi_burst_addr
    import axi_ram_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] incr_addr;

    assign step      = 32'd1 << size;
    assign incr_addr = addr + step;

`ifdef AXI_RAM_WRAP_EN
    logic [31:0] mask;

    // Wrap window is (len+1) beats of (1<<size) bytes, aligned to its own size.
    assign mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = incr_addr;
        unique case (burst)
            BURST_FIXED: next_addr = addr;
`ifdef AXI_RAM_WRAP_EN
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr_addr & mask);
`endif
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI3 slave serving one burst at a time from a single-port synchronous SRAM.
// WRAP addressing is enabled by defining AXI_RAM_WRAP_EN; otherwise WRAP behaves as INCR.
module axi_ram_responder
    import axi_ram_pkg::*;
#(
    parameter int unsigned RAM_AW = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [AXI_ID_W-1:0]   arid,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic [1:0]            arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,

    output logic [AXI_ID_W-1:0]   rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,

    input  logic [AXI_ID_W-1:0]   awid,
    input  logic [31:0]           awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,

    input  logic [AXI_ID_W-1:0]   wid,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,

    output logic [AXI_ID_W-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    output logic                  ram_en,
    output logic [3:0]            ram_wen,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    state_e              state_q;
    logic                last_rd_q;
    logic [AXI_ID_W-1:0] id_q;
    logic [31:0]         addr_q;
    logic [3:0]          len_q;
    logic [3:0]          beat_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                rd_pend_q;
    logic [31:0]         rdata_q;

    logic [31:0]         next_addr;
    logic                grant_rd;
    logic                grant_wr;
    logic                last_beat;

    logic unused;
    assign unused = ^{arlock, arcache, arprot, arlen[7:4], awlock, awcache, awprot, awlen[7:4],
                      wid, wlast};

    axi_burst_addr u_burst_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // On contention, serve whichever type did not go last.
    assign grant_rd  = arvalid & (~awvalid | ~last_rd_q);
    assign grant_wr  = awvalid & (~arvalid | last_rd_q);
    assign arready   = aresetn & (state_q == StIdle) & grant_rd;
    assign awready   = aresetn & (state_q == StIdle) & grant_wr;
    assign last_beat = (beat_q == len_q);

    assign rvalid = (state_q == StRdData);
    assign rid    = rvalid ? id_q : '0;
    assign rresp  = RESP_OKAY;
    assign rlast  = rvalid & last_beat;
    // SRAM data is live for one cycle after the read, then held in rdata_q.
    assign rdata  = rd_pend_q ? ram_rdata : rdata_q;

    assign wready = (state_q == StWrData);
    assign bvalid = (state_q == StWrResp);
    assign bid    = bvalid ? id_q : '0;
    assign bresp  = RESP_OKAY;

    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == StRdReq) begin
            ram_en   = 1'b1;
            ram_addr = addr_q[RAM_AW+1:2];
        end else if (state_q == StWrData && wvalid) begin
            ram_en    = 1'b1;
            ram_wen   = wstrb;
            ram_addr  = addr_q[RAM_AW+1:2];
            ram_wdata = wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            last_rd_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= 1'b0;
            if (rd_pend_q) begin
                rdata_q <= ram_rdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant_rd) begin
                        id_q      <= arid;
                        addr_q    <= araddr;
                        len_q     <= arlen[3:0];
                        size_q    <= arsize;
                        burst_q   <= arburst;
                        beat_q    <= '0;
                        last_rd_q <= 1'b1;
                        state_q   <= StRdReq;
                    end else if (grant_wr) begin
                        id_q      <= awid;
                        addr_q    <= awaddr;
                        len_q     <= awlen[3:0];
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        beat_q    <= '0;
                        last_rd_q <= 1'b0;
                        state_q   <= StWrData;
                    end
                end
                StRdReq: begin
                    rd_pend_q <= 1'b1;
                    state_q   <= StRdData;
                end
                StRdData: begin
                    if (rready) begin
                        if (last_beat) begin
                            state_q <= StIdle;
                        end else begin
                            addr_q  <= next_addr;
                            beat_q  <= beat_q + 4'd1;
                            state_q <= StRdReq;
                        end
                    end
                end
                StWrData: begin
                    if (wvalid) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 4'd1;
                        if (last_beat) begin
                            state_q <= StWrResp;
                        end
                    end
                end
                StWrResp: begin
                    if (bready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed self-checking bench for axi_ram_responder with a behavioural SRAM model.
module tb_axi_ram_responder;
    import axi_ram_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = BURST_INCR;
    logic [1:0]  arlock = '0;
    logic [3:0]  arcache = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = BURST_INCR;
    logic [1:0]  awlock = '0;
    logic [3:0]  awcache = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [15:0] rd_addrs [$];
    logic [31:0] r_data [$];
    logic        r_last [$];
    bit          is_rd [$];

    axi_ram_responder #(.RAM_AW(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 aclk = ~aclk;

    // Synchronous SRAM: one-cycle read latency, byte-lane writes, read-address log.
    always @(posedge aclk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
            if (ram_wen == 4'h0) rd_addrs.push_back(ram_addr);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, required finish before 300000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst);
        arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (arready) break;
            tick();
        end
        check("ar_handshake", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (awready) break;
            tick();
        end
        check("aw_handshake", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic r_collect(input int n);
        int w;
        rready = 1'b1;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (!rvalid && w < 20) begin
                tick();
                w++;
            end
            check("r_valid_wait", 32'(rvalid), 32'd1);
            r_data.push_back(rdata);
            r_last.push_back(rlast);
            tick();
        end
        rready = 1'b0;
    endtask

    initial begin
        int base;
        int w;
        bit stable;
        logic [15:0] exp_wrap [4];

        // Reset state, with both requests already pending.
        arid = 4'd1; araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1;
        awid = 4'd2; awaddr = 32'h300; awlen = 8'd0; awvalid = 1'b1;
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; rready = 1'b1; bready = 1'b1;
        tick();
        tick();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rid_bid", 32'({rid, bid, rlast}), 32'd0);

        // Arbitration with both valids held: R, W, R, W...
        aresetn = 1'b1;
        #1;
        for (int i = 0; i < 30; i++) begin
            if (arready) is_rd.push_back(1'b1);
            if (awready) is_rd.push_back(1'b0);
            tick();
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (4) tick();
        rready = 1'b0; bready = 1'b0;
        check("arb_grant_count_ge4", 32'(is_rd.size() >= 4), 32'd1);
        if (is_rd.size() >= 4) begin
            check("arb_grant0_read", 32'(is_rd[0]), 32'd1);
            check("arb_grant1_write", 32'(is_rd[1]), 32'd0);
            check("arb_grant2_read", 32'(is_rd[2]), 32'd1);
            check("arb_grant3_write", 32'(is_rd[3]), 32'd0);
        end

        // Single read, latency T+2.
        preload(16'h40, 32'hDEADBEEF);
        arid = 4'd3; araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
        arvalid = 1'b1;
        #1;
        check("rd1_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        #1;
        check("rd1_ram_en_t1", 32'(ram_en), 32'd1);
        check("rd1_ram_addr_t1", 32'(ram_addr), 32'h40);
        check("rd1_rvalid_t1", 32'(rvalid), 32'd0);
        tick();
        check("rd1_rvalid_t2", 32'(rvalid), 32'd1);
        check("rd1_rdata", rdata, 32'hDEADBEEF);
        check("rd1_rid", 32'(rid), 32'd3);
        check("rd1_rlast", 32'(rlast), 32'd1);
        check("rd1_rresp", 32'(rresp), 32'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd1_rvalid_done", 32'(rvalid), 32'd0);

        // INCR write of 1..4 at 0x200, then read it back.
        aw_send(4'd5, 32'h200, 8'd3);
        for (int i = 0; i < 4; i++) begin
            wvalid = 1'b1; wdata = i + 1; wstrb = 4'hF; wlast = (i == 3);
            #1;
            check("wr_wready", 32'(wready), 32'd1);
            check("wr_ram_wen", 32'(ram_wen), 32'hF);
            check("wr_ram_addr", 32'(ram_addr), 32'h80 + i);
            check("wr_ram_wdata", ram_wdata, i + 1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wr_bvalid_next", 32'(bvalid), 32'd1);
        check("wr_bid", 32'(bid), 32'd5);
        check("wr_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr_bvalid_done", 32'(bvalid), 32'd0);

        ar_send(4'd6, 32'h200, 8'd3, BURST_INCR);
        r_data.delete();
        r_last.delete();
        r_collect(4);
        for (int i = 0; i < 4; i++) begin
            check("rb_data", r_data[i], i + 1);
            check("rb_rlast", 32'(r_last[i]), 32'(i == 3));
        end

        // WRAP burst from 0x1C.
`ifdef AXI_RAM_WRAP_EN
        exp_wrap[0] = 16'h7; exp_wrap[1] = 16'h4; exp_wrap[2] = 16'h5; exp_wrap[3] = 16'h6;
`else
        exp_wrap[0] = 16'h7; exp_wrap[1] = 16'h8; exp_wrap[2] = 16'h9; exp_wrap[3] = 16'hA;
`endif
        base = rd_addrs.size();
        ar_send(4'd7, 32'h1C, 8'd3, BURST_WRAP);
        r_collect(4);
        check("wrap_read_count", rd_addrs.size() - base, 32'd4);
        if (rd_addrs.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) check("wrap_addr", 32'(rd_addrs[base + i]), 32'(exp_wrap[i]));
        end

        // Read backpressure: rready low for 5 cycles on beat 2.
        ar_send(4'd8, 32'h200, 8'd3, BURST_INCR);
        r_data.delete();
        r_last.delete();
        r_collect(1);
        check("bp_beat1", r_data[0], 32'd1);
        w = 0;
        while (!rvalid && w < 20) begin
            tick();
            w++;
        end
        base = rd_addrs.size();
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(rvalid === 1'b1 && rdata === 32'd2 && rid === 4'd8 && rlast === 1'b0))
                stable = 1'b0;
            tick();
        end
        check("bp_r_stable", 32'(stable), 32'd1);
        check("bp_no_extra_reads", rd_addrs.size() - base, 32'd0);
        r_data.delete();
        r_last.delete();
        r_collect(3);
        check("bp_beat2", r_data[0], 32'd2);
        check("bp_beat4", r_data[2], 32'd4);
        check("bp_rlast_beat4", 32'({r_last[0], r_last[1], r_last[2]}), 32'b001);

        // Write response backpressure: bready low for 3 cycles.
        aw_send(4'd9, 32'h300, 8'd0);
        wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!(bvalid === 1'b1 && bid === 4'd9)) stable = 1'b0;
            tick();
        end
        check("bp_b_stable", 32'(stable), 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bp_b_done", 32'(bvalid), 32'd0);

        // Reset pulsed during beat 2 of an 8-beat read.
        for (int i = 0; i < 8; i++) preload(16'h100 + 16'(i), 32'hA0 + i);
        ar_send(4'd10, 32'h400, 8'd7, BURST_INCR);
        r_data.delete();
        r_last.delete();
        r_collect(1);
        check("rst_mid_beat1", r_data[0], 32'hA0);
        w = 0;
        while (!rvalid && w < 20) begin
            tick();
            w++;
        end
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_rid_rlast", 32'({rid, rlast}), 32'd0);
        check("rst_mid_ram_en", 32'(ram_en), 32'd0);
        check("rst_mid_ready", 32'({arready, awready, wready, bvalid}), 32'd0);
        base = rd_addrs.size();
        tick();
        tick();
        check("rst_mid_no_access", rd_addrs.size() - base, 32'd0);
        aresetn = 1'b1;
        ar_send(4'd11, 32'h100, 8'd0, BURST_INCR);
        r_data.delete();
        r_last.delete();
        r_collect(1);
        check("post_rst_rdata", r_data[0], 32'hDEADBEEF);
        check("post_rst_rlast", 32'(r_last[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
